// File: rtl/sfp_pkg.sv
// sfp_pkg: shared types and helpers for the SFP accumulator bank.
// Holds the FSM state encoding, the mode encodings and the per-channel
// narrowing function (ReLU followed by saturate or pass-through).
package sfp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAIN = 2'd2
  } sfp_state_e;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Optional ReLU, then optional clamp to the signed range of outBw bits.
  // The caller keeps the low outBw bits, which truncates when satEn is 0.
  function automatic logic [63:0] sfpNarrow(input logic signed [63:0] val,
                                            input int outBw,
                                            input logic reluEn,
                                            input logic satEn);
    logic signed [63:0] res;
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    res  = val;
    if (reluEn && (val < 64'sd0)) res = 64'sd0;
    maxV = (64'sd1 <<< (outBw - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (outBw - 1));
    if (satEn) begin
      if (res > maxV)      res = maxV;
      else if (res < minV) res = minV;
    end
    return res;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// sfp_lane: one output channel of the accumulator bank.
// Holds the read-modify-write adder with its stage-2 forwarding mux and the
// narrowing path used for drain and bypass output.
// Build option: SFP_SAT_EN selects saturating narrowing instead of truncation.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 20
) (
  input  logic [ACC_BW-1:0]  rdAcc_i,
  input  logic [ACC_BW-1:0]  fwdAcc_i,
  input  logic               fwdSel_i,
  input  logic               first_i,
  input  logic [PSUM_BW-1:0] psum_i,
  output logic [ACC_BW-1:0]  sum_o,
  input  logic [ACC_BW-1:0]  narrowIn_i,
  input  logic               reluEn_i,
  output logic [PSUM_BW-1:0] narrow_o
);

`ifdef SFP_SAT_EN
  localparam logic SatEn = 1'b1;
`else
  localparam logic SatEn = 1'b0;
`endif

  logic [ACC_BW-1:0] psumExt;
  logic [ACC_BW-1:0] base;

  // Accumulate: the previous cycle's write wins over the stale stage-1 read.
  always_comb begin
    psumExt = ACC_BW'($signed(psum_i));
    base    = fwdSel_i ? fwdAcc_i : rdAcc_i;
    sum_o   = first_i ? psumExt : base + psumExt;
  end

  // Narrow an accumulator-width value down to the output channel width.
  always_comb begin
    narrow_o = PSUM_BW'(sfpNarrow(64'($signed(narrowIn_i)), PSUM_BW, reluEn_i, SatEn));
  end

endmodule

// File: rtl/sfp_acc_bank.sv
// sfp_acc_bank: DEPTH-entry, COL-channel partial-sum accumulator bank.
// WS mode accumulates psum vectors per entry through a two-stage
// read-modify-write pipeline and drains entries 0..DEPTH-1 with ReLU and
// narrowing; OS mode is a one-deep registered pass-through on the same port.
// Build option: SFP_SAT_EN (saturating narrowing, inside sfp_lane).
module sfp_acc_bank
  import sfp_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 20,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   relu_en,
  input  logic                   clr_start,
  input  logic                   drain_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic                   in_first,
  input  logic [COL*PSUM_BW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_addr,
  output logic [COL*PSUM_BW-1:0] out_data,
  output logic                   busy
);

  sfp_state_e             state_q;
  logic [AW-1:0]          clrPtr_q;
  logic                   drainReq_q;
  logic                   idleRdy_q;
  logic                   busy_q;
  logic                   s1Valid_q;
  logic                   s1First_q;
  logic [AW-1:0]          s1Addr_q;
  logic [COL*PSUM_BW-1:0] s1Data_q;
  logic [COL*ACC_BW-1:0]  rd_q;
  logic                   wbValid_q;
  logic [AW-1:0]          wbAddr_q;
  logic [COL*ACC_BW-1:0]  wb_q;
  logic                   outValid_q;
  logic [AW-1:0]          outAddr_q;
  logic [COL*PSUM_BW-1:0] outData_q;
  logic [COL*ACC_BW-1:0]  mem_q [DEPTH];

  logic                   accept;
  logic                   fwdSel;
  logic                   osPath;
  logic [AW-1:0]          drainIdx;
  logic [COL*ACC_BW-1:0]  drainWord;
  logic [COL*ACC_BW-1:0]  sum;
  logic [COL*PSUM_BW-1:0] narrowed;

  // Handshake, forwarding select and the entry feeding the drain output.
  always_comb begin
    in_ready  = idleRdy_q & ((mode == MODE_WS) | ~outValid_q | out_ready);
    accept    = in_valid & in_ready;
    fwdSel    = wbValid_q && (wbAddr_q == s1Addr_q);
    osPath    = (state_q == S_IDLE) && !drainReq_q && (mode == MODE_OS);
    drainIdx  = '0;
    if ((state_q == S_DRAIN) && (outAddr_q != AW'(DEPTH - 1))) drainIdx = outAddr_q + 1'b1;
    drainWord = mem_q[drainIdx];
  end

  for (genvar c = 0; c < COL; c++) begin : gLane
    logic [ACC_BW-1:0] srcAcc;
    assign srcAcc = osPath ? ACC_BW'($signed(in_data[c*PSUM_BW +: PSUM_BW]))
                           : drainWord[c*ACC_BW +: ACC_BW];
    sfp_lane #(.PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW)) uLane (
      .rdAcc_i   (rd_q[c*ACC_BW +: ACC_BW]),
      .fwdAcc_i  (wb_q[c*ACC_BW +: ACC_BW]),
      .fwdSel_i  (fwdSel),
      .first_i   (s1First_q),
      .psum_i    (s1Data_q[c*PSUM_BW +: PSUM_BW]),
      .sum_o     (sum[c*ACC_BW +: ACC_BW]),
      .narrowIn_i(srcAcc),
      .reluEn_i  (relu_en),
      .narrow_o  (narrowed[c*PSUM_BW +: PSUM_BW])
    );
  end

  // Pipeline, entry storage, FSM and registered outputs; clear writes are
  // placed after the pipeline write so a colliding clear always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clrPtr_q   <= '0;
      drainReq_q <= 1'b0;
      idleRdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      s1Valid_q  <= 1'b0;
      s1First_q  <= 1'b0;
      s1Addr_q   <= '0;
      s1Data_q   <= '0;
      rd_q       <= '0;
      wbValid_q  <= 1'b0;
      wbAddr_q   <= '0;
      wb_q       <= '0;
      outValid_q <= 1'b0;
      outAddr_q  <= '0;
      outData_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wbValid_q <= s1Valid_q;
      s1Valid_q <= 1'b0;
      if (s1Valid_q) begin
        mem_q[s1Addr_q] <= sum;
        wbAddr_q        <= s1Addr_q;
        wb_q            <= sum;
      end
      if (accept && (mode == MODE_WS)) begin
        s1Valid_q <= 1'b1;
        s1Addr_q  <= in_addr;
        s1First_q <= in_first;
        s1Data_q  <= in_data;
        rd_q      <= mem_q[in_addr];
      end
      case (state_q)
        S_IDLE: begin
          if (accept && (mode == MODE_OS)) begin
            outValid_q <= 1'b1;
            outAddr_q  <= in_addr;
            outData_q  <= narrowed;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
          end
          if (clr_start) begin
            state_q    <= S_CLEAR;
            clrPtr_q   <= '0;
            busy_q     <= 1'b1;
            idleRdy_q  <= 1'b0;
            drainReq_q <= 1'b0;
          end else if (drainReq_q && !s1Valid_q && !outValid_q) begin
            state_q    <= S_DRAIN;
            busy_q     <= 1'b1;
            drainReq_q <= 1'b0;
            outValid_q <= 1'b1;
            outAddr_q  <= '0;
            outData_q  <= narrowed;
          end else if (drainReq_q || (drain_start && (mode == MODE_WS))) begin
            drainReq_q <= 1'b1;
            idleRdy_q  <= 1'b0;
          end else begin
            idleRdy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (out_ready) outValid_q <= 1'b0;
          mem_q[clrPtr_q] <= '0;
          clrPtr_q        <= clrPtr_q + 1'b1;
          if (clrPtr_q == AW'(DEPTH - 1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            idleRdy_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (outAddr_q == AW'(DEPTH - 1)) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              idleRdy_q  <= 1'b1;
              outValid_q <= 1'b0;
            end else begin
              outAddr_q <= outAddr_q + 1'b1;
              outData_q <= narrowed;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign out_addr  = outAddr_q;
  assign out_data  = outData_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sfp_acc_bank.sv
// tb_sfp_acc_bank: directed scoreboard bench for sfp_acc_bank.
// Expected outputs are queued by the stimulus; a negedge monitor pops and
// compares on every output handshake and checks stall stability.
// Saturation expectations follow SFP_SAT_EN.
module tb_sfp_acc_bank;

  localparam int COL = 8;
  localparam int PSUM_BW = 16;
  localparam int ACC_BW = 20;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int DW = COL * PSUM_BW;

  logic          clk = 1'b0;
  logic          reset, mode, relu_en, clr_start, drain_start;
  logic          in_valid, in_ready, in_first;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, busy;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] expAddr[$];
  logic [DW-1:0] expData[$];
  logic [15:0]   expEntry[DEPTH];

  logic          stallPrev = 1'b0;
  logic [AW-1:0] holdAddr;
  logic [DW-1:0] holdData;

  sfp_acc_bank #(.COL(COL), .PSUM_BW(PSUM_BW), .ACC_BW(ACC_BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mode(mode), .relu_en(relu_en),
    .clr_start(clr_start), .drain_start(drain_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_first(in_first), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic recordFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=no event required=event within bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] allVec(input logic [15:0] v);
    return {COL{v}};
  endfunction

  function automatic logic [DW-1:0] osVec(input int i);
    logic [DW-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PSUM_BW +: PSUM_BW] = 16'(i * 1000 - 3000 + c * 7);
    return v;
  endfunction

  function automatic logic [DW-1:0] reluVec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int c = 0; c < COL; c++) if (v[c*PSUM_BW + PSUM_BW - 1]) r[c*PSUM_BW +: PSUM_BW] = '0;
    return r;
  endfunction

  // Drive one input vector and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic first,
                               input logic [DW-1:0] data, output int waits);
    in_addr  = addr;
    in_first = first;
    in_data  = data;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) recordFail("acceptTimeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pushDrain(input logic relu);
    logic [15:0] e;
    for (int k = 0; k < DEPTH; k++) begin
      e = expEntry[k];
      if (relu && e[15]) e = 16'd0;
      expAddr.push_back(AW'(k));
      expData.push_back(allVec(e));
    end
  endtask

  task automatic runDrain(input logic toggle);
    int n;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    if (!busy) recordFail("drainStart");
    n = 0;
    while (busy && n < 200) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      n++;
    end
    if (busy) recordFail("drainEnd");
    out_ready = 1'b1;
    checkOutput("drainAllSeen", DW'(expData.size()), DW'(0));
  endtask

  // Scoreboard monitor: compare every handshake and check stall stability.
  always @(negedge clk) begin
    if (reset) begin
      stallPrev <= 1'b0;
    end else begin
      if (stallPrev && out_valid) begin
        checkOutput("holdAddr", DW'(out_addr), DW'(holdAddr));
        checkOutput("holdData", out_data, holdData);
      end
      if (out_valid && out_ready) begin
        if (expData.size() == 0) begin
          recordFail("unexpectedOutput");
        end else begin
          checkOutput("outAddr", DW'(out_addr), DW'(expAddr.pop_front()));
          checkOutput("outData", out_data, expData.pop_front());
        end
      end
      stallPrev <= out_valid && !out_ready;
      holdAddr  <= out_addr;
      holdData  <= out_data;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waits;
    int cnt;
    reset = 1'b1; mode = 1'b0; relu_en = 1'b0; clr_start = 1'b0; drain_start = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) expEntry[k] = 16'd0;
    tick();
    tick();
    checkOutput("rstOutValid", DW'(out_valid), DW'(0));
    checkOutput("rstBusy", DW'(busy), DW'(0));
    checkOutput("rstInReady", DW'(in_ready), DW'(0));
    checkOutput("rstOutAddr", DW'(out_addr), DW'(0));
    checkOutput("rstOutData", out_data, DW'(0));
    reset = 1'b0;
    tick();

    $display("[TB] clear then drain");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    checkOutput("clearInReady", DW'(in_ready), DW'(0));
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    checkOutput("clearBusyCycles", DW'(cnt), DW'(16));
    pushDrain(1'b0);
    runDrain(1'b0);

    $display("[TB] accumulate with forwarding");
    applyStimulus(4'd3, 1'b1, allVec(16'd5), waits);
    applyStimulus(4'd3, 1'b0, allVec(-16'sd2), waits);
    checkOutput("wsNoBubble1", DW'(waits), DW'(0));
    applyStimulus(4'd3, 1'b0, allVec(-16'sd2), waits);
    checkOutput("wsNoBubble2", DW'(waits), DW'(0));
    expEntry[3] = 16'd1;
    pushDrain(1'b0);
    runDrain(1'b0);

    $display("[TB] accumulate negative with relu");
    applyStimulus(4'd3, 1'b1, allVec(16'd5), waits);
    applyStimulus(4'd3, 1'b0, allVec(-16'sd9), waits);
    applyStimulus(4'd3, 1'b0, allVec(-16'sd9), waits);
    expEntry[3] = 16'hFFF3;
    relu_en = 1'b1;
    pushDrain(1'b1);
    runDrain(1'b0);
    relu_en = 1'b0;
    pushDrain(1'b0);
    runDrain(1'b0);

    $display("[TB] narrowing of 3 x 30000");
    applyStimulus(4'd0, 1'b1, allVec(16'd30000), waits);
    applyStimulus(4'd0, 1'b0, allVec(16'd30000), waits);
    applyStimulus(4'd0, 1'b0, allVec(16'd30000), waits);
`ifdef SFP_SAT_EN
    expEntry[0] = 16'd32767;
`else
    expEntry[0] = 16'd24464;
`endif
    pushDrain(1'b0);
    runDrain(1'b0);

    $display("[TB] drain under backpressure");
    pushDrain(1'b0);
    runDrain(1'b1);

    $display("[TB] OS bypass streaming");
    mode = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      expAddr.push_back(AW'(i));
      expData.push_back(osVec(i));
      applyStimulus(AW'(i), 1'b0, osVec(i), waits);
      checkOutput("osNoWait", DW'(waits), DW'(0));
      checkOutput("osValidNext", DW'(out_valid), DW'(1));
      checkOutput("osAddrNext", DW'(out_addr), DW'(i));
      checkOutput("osInReady", DW'(in_ready), DW'(1));
    end
    relu_en = 1'b1;
    expAddr.push_back(AW'(9));
    expData.push_back(reluVec(osVec(1)));
    applyStimulus(4'd9, 1'b0, osVec(1), waits);
    relu_en = 1'b0;
    tick();
    checkOutput("osDrained", DW'(out_valid), DW'(0));

    $display("[TB] OS bypass stall");
    out_ready = 1'b0;
    expAddr.push_back(AW'(12));
    expData.push_back(osVec(5));
    applyStimulus(4'd12, 1'b0, osVec(5), waits);
    checkOutput("osStallReady", DW'(in_ready), DW'(0));
    tick();
    tick();
    tick();
    checkOutput("osStallReady2", DW'(in_ready), DW'(0));
    checkOutput("osStallValid", DW'(out_valid), DW'(1));
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("osStallDone", DW'(expData.size()), DW'(0));
    mode = 1'b0;
    tick();

    $display("[TB] reset during drain");
    pushDrain(1'b0);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    cnt = 0;
    while (!(out_valid && out_addr == 4'd5) && cnt < 50) begin
      tick();
      cnt++;
    end
    if (!(out_valid && out_addr == 4'd5)) recordFail("reachEntry5");
    reset = 1'b1;
    tick();
    expAddr.delete();
    expData.delete();
    checkOutput("midRstOutValid", DW'(out_valid), DW'(0));
    checkOutput("midRstBusy", DW'(busy), DW'(0));
    checkOutput("midRstOutAddr", DW'(out_addr), DW'(0));
    reset = 1'b0;
    tick();
    for (int k = 0; k < DEPTH; k++) expEntry[k] = 16'd0;
    pushDrain(1'b0);
    runDrain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
